// File: rtl/pipeline_sequencer_nstage.sv
// Job sequencer for an N-stage datapath: issues TOTAL_INPUTS indices, tracks
// per-stage occupancy with bubble-collapsing backpressure, and pulses done on completion.
module pipeline_sequencer_nstage #(
  parameter int NUM_STAGES   = 3,
  parameter int TOTAL_INPUTS = 16,
  localparam int IDX_W = (TOTAL_INPUTS > 1) ? $clog2(TOTAL_INPUTS) : 1,
  localparam int CNT_W = $clog2(TOTAL_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  src_valid,
  output logic                  src_ready,
  output logic [IDX_W-1:0]      input_index,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(TOTAL_INPUTS - 1);
  localparam logic [CNT_W-1:0] TOTAL      = CNT_W'(TOTAL_INPUTS);

  state_t                state, state_next;
  logic [CNT_W-1:0]      issue_cnt, retire_cnt, retire_cnt_next;
  logic [NUM_STAGES:0]   rdy;
  logic [NUM_STAGES-1:0] valid_next;
  logic [IDX_W-1:0]      tag [NUM_STAGES];
  logic                  issue, retire;

  // Ready ripples back from the output; an empty stage is always ready.
  always_comb begin : ready_chain
    logic chain;
    chain = out_ready;
    rdy   = '0;
    rdy[NUM_STAGES] = out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      chain  = !stage_valid[i] || chain;
      rdy[i] = chain;
    end
  end

  assign issue           = src_valid && src_ready;
  assign out_valid       = stage_valid[NUM_STAGES-1];
  assign retire          = out_valid && out_ready;
  assign retire_cnt_next = retire_cnt + CNT_W'(retire);
  assign input_index     = issue_cnt[IDX_W-1:0];
  assign out_index       = tag[NUM_STAGES-1];

  // NOTE: every output of a combinational block is assigned a default first so no latch is inferred.
  always_comb begin
    stage_en    = '0;
    stage_en[0] = issue;
    for (int i = 1; i < NUM_STAGES; i++) stage_en[i] = stage_valid[i-1] && rdy[i];
  end

  always_comb begin
    valid_next = '0;
    for (int i = 0; i < NUM_STAGES; i++)
      valid_next[i] = stage_en[i] || (stage_valid[i] && !rdy[i+1]);
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (issue && issue_cnt == LAST_ISSUE) state_next = DRAIN;
      DRAIN:   if (retire_cnt_next == TOTAL && valid_next == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_comb begin
    src_ready = (state == RUN) && rdy[0];
    busy      = (state == RUN) || (state == DRAIN);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      issue_cnt   <= '0;
      retire_cnt  <= '0;
      // NOTE: the tag array is small and observable on out_index, so it is reset rather than left as plain storage.
      for (int i = 0; i < NUM_STAGES; i++) tag[i] <= '0;
    end else if (abort) begin
      stage_valid <= '0;
      issue_cnt   <= '0;
      retire_cnt  <= '0;
    end else begin
      stage_valid <= valid_next;
      if (state == IDLE && start) begin
        issue_cnt  <= '0;
        retire_cnt <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
        retire_cnt <= retire_cnt_next;
      end
      if (stage_en[0]) tag[0] <= input_index;
      for (int i = 1; i < NUM_STAGES; i++)
        if (stage_en[i]) tag[i] <= tag[i-1];
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer_nstage.sv
// Directed bench for pipeline_sequencer_nstage (3 stages, 4 inputs) with an
// issue/retire scoreboard that checks index order and timing.
module tb_pipeline_sequencer_nstage;

  localparam int NS = 3;
  localparam int TI = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort, src_valid, out_ready;
  logic          src_ready, out_valid, busy, done;
  logic [1:0]    input_index, out_index;
  logic [NS-1:0] stage_en, stage_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int model_idx, retired;
  int first_issue_cyc, last_issue_cyc, first_ret_cyc, last_ret_cyc;
  int sb[$];

  pipeline_sequencer_nstage #(.NUM_STAGES(NS), .TOTAL_INPUTS(TI)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .input_index(input_index),
    .stage_en(stage_en), .stage_valid(stage_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_job();
    sb.delete();
    model_idx       = 0;
    retired         = 0;
    first_issue_cyc = -1;
    last_issue_cyc  = -1;
    first_ret_cyc   = -1;
    last_ret_cyc    = -1;
  endtask

  // Sample handshakes mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    int expv;
    @(negedge clk);
    if (src_valid && src_ready) begin
      check("input_index", 32'(input_index), model_idx);
      sb.push_back(model_idx);
      if (first_issue_cyc < 0) first_issue_cyc = cyc;
      last_issue_cyc = cyc;
      model_idx++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("retire_with_empty_scoreboard", sb.size(), 1);
      end else begin
        expv = sb.pop_front();
        check("out_index", 32'(out_index), expv);
      end
      if (first_ret_cyc < 0) first_ret_cyc = cyc;
      last_ret_cyc = cyc;
      retired++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to_done();
    for (int i = 0; i < 60 && !done; i++) tick();
    check("done_seen", done, 1);
    check("done_after_last_retire", cyc - last_ret_cyc, 1);
    check("busy_in_done", busy, 0);
    check("job_retired", retired, TI);
    check("scoreboard_empty", sb.size(), 0);
    tick();
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_stage_valid"}, stage_valid, 0);
    check({tag, "_stage_en"}, stage_en, 0);
    check({tag, "_input_index"}, input_index, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_src_ready"}, src_ready, 0);
  endtask

  initial begin
    int dcount;
    rst = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
    new_job();
    tick(); tick();
    check_idle_outputs("reset");
    check("reset_out_index", out_index, 0);
    rst = 1'b0;
    tick();

    // Streaming job, no stalls.
    new_job();
    start = 1'b1; src_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", busy, 1);
    run_to_done();
    check("latency_first_out", first_ret_cyc - first_issue_cyc, NS);
    check("issue_back_to_back", last_issue_cyc - first_issue_cyc, TI - 1);
    check("retire_back_to_back", last_ret_cyc - first_ret_cyc, TI - 1);
    src_valid = 1'b0;

    // Full pipe held by a stalled output for five cycles.
    new_job();
    start = 1'b1; src_valid = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      check("stall_stage_valid", stage_valid, 3'b111);
      check("stall_src_ready", src_ready, 0);
      check("stall_out_index", out_index, 0);
      check("stall_stage_en", stage_en, 0);
      tick();
    end
    out_ready = 1'b1;
    run_to_done();
    src_valid = 1'b0;

    // Input gaps collapse behind the stalled output.
    new_job();
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    src_valid = 1'b1; tick();
    src_valid = 1'b0; tick();
    src_valid = 1'b1; tick();
    src_valid = 1'b1; tick();
    src_valid = 1'b0; tick();
    src_valid = 1'b1; tick();
    check("gaps_collapsed", stage_valid, 3'b111);
    check("gaps_issued", model_idx, 3);
    check("gaps_head", out_index, 0);
    out_ready = 1'b1;
    run_to_done();
    src_valid = 1'b0;

    // Abort during drain with the first stage already empty.
    new_job();
    start = 1'b1; src_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("drain_busy", busy, 1);
    check("drain_src_ready", src_ready, 0);
    tick();
    check("drain_stage_valid", stage_valid, 3'b110);
    abort = 1'b1;
    dcount = 0;
    tick();
    abort = 1'b0; src_valid = 1'b0;
    check_idle_outputs("abort");
    new_job();
    for (int i = 0; i < 3; i++) begin
      dcount += 32'(done);
      tick();
    end
    check("no_done_after_abort", dcount, 0);

    // start with abort in IDLE, then start held while running.
    new_job();
    start = 1'b1; abort = 1'b1; src_valid = 1'b1; out_ready = 1'b1;
    tick();
    abort = 1'b0;
    check("start_abort_stays_idle", busy, 0);
    check("start_abort_src_ready", src_ready, 0);
    tick();
    check("start_enters_run", busy, 1);
    tick(); tick();
    check("start_ignored_in_run", busy, 1);
    check("start_ignored_index", input_index, 2);
    start = 1'b0;
    run_to_done();
    src_valid = 1'b0;

    // Reset mid-run after two issues, then a complete job.
    new_job();
    start = 1'b1; src_valid = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_reset_issues", model_idx, 2);
    rst = 1'b1;
    tick();
    check_idle_outputs("midrun_reset");
    check("midrun_reset_out_index", out_index, 0);
    rst = 1'b0;
    new_job();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done();
    src_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer_nstage.md
PIPELINE_SEQUENCER_NSTAGE -- requirements
Module: pipeline_sequencer_nstage

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of pipeline stages sequenced (>=1).
REQ-002 SHALL have parameter TOTAL_INPUTS, default 16, inputs per job (>=1).
REQ-003 SHALL derive IDX_W = max(1, clog2(TOTAL_INPUTS)) and CNT_W = clog2(TOTAL_INPUTS+1).
REQ-004 SHALL use one clock; reset is synchronous and active-high; ports named clk and rst.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  job request; sampled only in IDLE.
REQ-008 abort  input  1  cancel job; flushes pipeline.
REQ-009 src_valid  input  1  upstream input data available.
REQ-010 src_ready  output  1  controller accepts an input this cycle.
REQ-011 input_index  output  IDX_W  index of the next input to issue.
REQ-012 stage_en  output  NUM_STAGES  per-stage datapath register load enable.
REQ-013 stage_valid  output  NUM_STAGES  per-stage occupancy.
REQ-014 out_valid  output  1  final stage holds a result.
REQ-015 out_ready  input  1  downstream accepts the result.
REQ-016 out_index  output  IDX_W  input index tag of the result at the output.
REQ-017 busy  output  1  high in RUN or DRAIN.
REQ-018 done  output  1  one-cycle pulse at job completion.

Function
REQ-019 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE->RUN on start && !abort; issue and retire counters cleared on that edge.
REQ-021 issue = src_valid && src_ready; src_ready = (state==RUN) && rdy[0].
REQ-022 rdy[NUM_STAGES] = out_ready; rdy[i] = !stage_valid[i] || rdy[i+1] (bubble-collapsing, combinational).
REQ-023 stage_en[0] = issue; stage_en[i>0] = stage_valid[i-1] && rdy[i].
REQ-024 Next stage_valid[i] = stage_en[i] ? 1 : (rdy[i+1] ? 0 : stage_valid[i]).
REQ-025 Each stage SHALL carry an IDX_W tag; stage 0 loads input_index on issue, stage i loads tag[i-1] when stage_en[i]; out_index = tag[NUM_STAGES-1].
REQ-026 out_valid = stage_valid[NUM_STAGES-1]; retire = out_valid && out_ready.
REQ-027 Latency: with no stall, input issued on edge k SHALL present out_valid after edge k+NUM_STAGES-1 (visible in cycle following it), i.e. NUM_STAGES register stages.
REQ-028 Issue counter (CNT_W) increments on issue; input_index = low IDX_W bits; no wrap within a job.
REQ-029 RUN->DRAIN on the edge where the TOTAL_INPUTS-th issue occurs; src_ready SHALL be 0 in DRAIN.
REQ-030 DRAIN->DONE when retire counter reaches TOTAL_INPUTS and all stage_valid are 0.
REQ-031 DONE SHALL last exactly one cycle with done=1, then ->IDLE.
REQ-032 abort in any state SHALL, at next edge, force IDLE, clear stage_valid and counters; no done pulse; abort beats start.
REQ-033 start outside IDLE SHALL be ignored.
REQ-034 Simultaneous issue and retire in one cycle SHALL both take effect; full pipeline with out_ready=1 sustains one issue per cycle.
REQ-035 out_valid held high with stable out_index while out_ready=0.

Reset
REQ-036 On rst: state IDLE, stage_valid=0, tags=0, counters=0, input_index=0, busy=0, done=0; rst overrides abort/start.
REQ-037 rst mid-job SHALL discard all in-flight data with no done pulse.

Verification (NUM_STAGES=3, TOTAL_INPUTS=4)
REQ-038 start, src_valid=1, out_ready=1 -> issues indices 0..3 on consecutive cycles, out_index 0..3 on consecutive cycles beginning 3 cycles after first issue, done one cycle after last retire.
REQ-039 Full pipe, out_ready=0 for 5 cycles -> stage_valid=3'b111, src_ready=0, out_index=0 held; resume -> no loss/duplication.
REQ-040 src_valid gaps (1,0,1,1,0,1) -> bubbles collapse behind stalled output; order 0..3 preserved.
REQ-041 abort during DRAIN with stage_valid=3'b110 -> next cycle IDLE, stage_valid=0, done never asserted.
REQ-042 start asserted during RUN, and start+abort in IDLE -> both ignored, state stays.
REQ-043 rst asserted mid-RUN after 2 issues -> all outputs at reset values next cycle; subsequent start runs full 4-input job.
